byte_data_memory: RTL and testbench

//   Parametrised MEM-stage data memory: byte-addressable, big-endian, byte/half/word

---
 rtl/byte_data_memory.sv | 141 ++++++++++++++
 tb/tb_byte_data_memory.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/byte_data_memory.sv
// Byte-addressable big-endian MEM-stage data memory with a word-per-cycle clear FSM.
// Optional feature macro DMEM_PRELOAD_EN: preload switch nibbles into display slots during init.
module byte_data_memory #(
    parameter int DEPTH        = 32,
    parameter int NUM_SLOTS    = 8,
    parameter int SLOT_W       = 4,
    localparam int IN_W        = NUM_SLOTS * SLOT_W,
    localparam int AW          = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst_i,
    input  logic [IN_W-1:0]        in_i,
    input  logic                   mem_write_i,
    input  logic                   mem_read_i,
    input  logic [1:0]             size_i,
    input  logic                   unsigned_i,
    input  logic [31:0]            addr_i,
    input  logic [31:0]            wdata_i,
    output logic [31:0]            rdata_o,
    output logic                   busy_o,
    output logic                   misalign_o,
    output logic [IN_W-1:0]        out_o,
    output logic [32*NUM_SLOTS-1:0] slot_o
);
    localparam int WORDS = DEPTH / 4;
    localparam int PW    = AW - 2;

    typedef enum logic {ST_INIT, ST_RUN} state_e;

    state_e          state_q, state_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic            misalign_q, misalign_d;
    logic [7:0]      mem_q [DEPTH];
    logic [7:0]      mem_d [DEPTH];

    logic [AW-1:0]   a0, a1, a2, a3;
    logic            run;
    logic            misaligned;

    assign a0  = addr_i[AW-1:0];
    assign a1  = a0 + AW'(1);
    assign a2  = a0 + AW'(2);
    assign a3  = a0 + AW'(3);
    assign run = (state_q == ST_RUN);

    assign misaligned = ((size_i == 2'b01) && a0[0]) ||
                        (size_i[1] && (a0[1:0] != 2'b00));

    // Upper address bits alias onto the decoded range.
    logic unused_addr;
    assign unused_addr = ^addr_i[31:AW];

`ifndef DMEM_PRELOAD_EN
    logic unused_in;
    assign unused_in = ^in_i;
`endif

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        misalign_d = (mem_read_i | mem_write_i) & misaligned & run;
        if (state_q == ST_INIT) begin
            ptr_d = ptr_q + PW'(1);
            if (ptr_q == PW'(WORDS - 1)) begin
                state_d = ST_RUN;
            end
        end
    end

    always_comb begin
        mem_d = mem_q;
        if (!rst_i) begin
            if (state_q == ST_INIT) begin
                for (int i = 0; i < 4; i++) begin
                    mem_d[{ptr_q, 2'(i)}] = 8'h00;
                end
`ifdef DMEM_PRELOAD_EN
                for (int k = 0; k < NUM_SLOTS; k++) begin
                    if (ptr_q == PW'(k)) begin
                        mem_d[{ptr_q, 2'b11}] = 8'(in_i[IN_W-1-SLOT_W*k -: SLOT_W]);
                    end
                end
`endif
            end else if (mem_write_i && !misaligned) begin
                case (size_i)
                    2'b00: mem_d[a0] = wdata_i[7:0];
                    2'b01: begin
                        mem_d[a0] = wdata_i[15:8];
                        mem_d[a1] = wdata_i[7:0];
                    end
                    default: begin
                        mem_d[a0] = wdata_i[31:24];
                        mem_d[a1] = wdata_i[23:16];
                        mem_d[a2] = wdata_i[15:8];
                        mem_d[a3] = wdata_i[7:0];
                    end
                endcase
            end
        end
    end

    // Loads read the pre-edge array, so a same-cycle store is not forwarded.
    always_comb begin
        rdata_o = 32'h0;
        if (run && mem_read_i && !misaligned) begin
            case (size_i)
                2'b00: rdata_o = unsigned_i ? {24'h0, mem_q[a0]}
                                            : {{24{mem_q[a0][7]}}, mem_q[a0]};
                2'b01: rdata_o = unsigned_i ? {16'h0, mem_q[a0], mem_q[a1]}
                                            : {{16{mem_q[a0][7]}}, mem_q[a0], mem_q[a1]};
                default: rdata_o = {mem_q[a0], mem_q[a1], mem_q[a2], mem_q[a3]};
            endcase
        end
    end

    always_comb begin
        out_o  = '0;
        slot_o = '0;
        for (int k = 0; k < NUM_SLOTS; k++) begin
            out_o[IN_W-1-SLOT_W*k -: SLOT_W] = mem_q[4*k+3][SLOT_W-1:0];
            slot_o[32*k +: 32] = {mem_q[4*k], mem_q[4*k+1], mem_q[4*k+2], mem_q[4*k+3]};
        end
    end

    assign busy_o     = (state_q == ST_INIT);
    assign misalign_o = misalign_q;

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
        if (rst_i) begin
            state_q    <= ST_INIT;
            ptr_q      <= '0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            misalign_q <= misalign_d;
        end
    end

endmodule

// File: tb/tb_byte_data_memory.sv
// Bench for byte_data_memory: directed cases plus random accesses against a byte-array model.
module tb_byte_data_memory;
    localparam int DEPTH     = 32;
    localparam int NUM_SLOTS = 8;
    localparam int SLOT_W    = 4;
    localparam int IN_W      = NUM_SLOTS * SLOT_W;
    localparam int WORDS     = DEPTH / 4;

    logic                    clk = 1'b0;
    logic                    rst_i;
    logic [IN_W-1:0]         in_i;
    logic                    mem_write_i;
    logic                    mem_read_i;
    logic [1:0]              size_i;
    logic                    unsigned_i;
    logic [31:0]             addr_i;
    logic [31:0]             wdata_i;
    logic [31:0]             rdata_o;
    logic                    busy_o;
    logic                    misalign_o;
    logic [IN_W-1:0]         out_o;
    logic [32*NUM_SLOTS-1:0] slot_o;

    int checks = 0;
    int errors = 0;
    logic [7:0]      model_mem [DEPTH];
    logic [IN_W-1:0] in_val;

    byte_data_memory #(.DEPTH(DEPTH), .NUM_SLOTS(NUM_SLOTS), .SLOT_W(SLOT_W)) dut (
        .clk(clk), .rst_i(rst_i), .in_i(in_i), .mem_write_i(mem_write_i),
        .mem_read_i(mem_read_i), .size_i(size_i), .unsigned_i(unsigned_i),
        .addr_i(addr_i), .wdata_i(wdata_i), .rdata_o(rdata_o), .busy_o(busy_o),
        .misalign_o(misalign_o), .out_o(out_o), .slot_o(slot_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int nbytes(input logic [1:0] sz);
        return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    endfunction

    function automatic bit model_mis(input logic [1:0] sz, input logic [31:0] addr);
        return (int'(addr[1:0]) % nbytes(sz)) != 0;
    endfunction

    function automatic logic [31:0] model_load(input logic [1:0] sz, input bit uns,
                                               input logic [31:0] addr);
        int n = nbytes(sz);
        int a = int'(addr % DEPTH);
        longint v = 0;
        for (int i = 0; i < n; i++) v = v * 256 + longint'(model_mem[(a + i) % DEPTH]);
        if (!uns && n < 4 && v >= (longint'(1) << (8 * n - 1)))
            v = v + (longint'(1) << 32) - (longint'(1) << (8 * n));
        return v[31:0];
    endfunction

    function automatic void model_store(input logic [1:0] sz, input logic [31:0] addr,
                                        input logic [31:0] wd);
        int n = nbytes(sz);
        int a = int'(addr % DEPTH);
        for (int i = 0; i < n; i++)
            model_mem[(a + i) % DEPTH] = 8'((wd >> (8 * (n - 1 - i))) & 32'hFF);
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < DEPTH; i++) model_mem[i] = 8'h00;
`ifdef DMEM_PRELOAD_EN
        for (int k = 0; k < NUM_SLOTS; k++)
            model_mem[4 * k + 3] = 8'((in_val >> (IN_W - SLOT_W * (k + 1))) % 16);
`endif
    endfunction

    function automatic logic [IN_W-1:0] exp_out();
        logic [IN_W-1:0] r = '0;
        for (int k = 0; k < NUM_SLOTS; k++)
            r = (r << SLOT_W) | IN_W'(model_mem[4 * k + 3] % 16);
        return r;
    endfunction

    task automatic check_view();
        check("out_o", out_o, exp_out());
        for (int k = 0; k < NUM_SLOTS; k++)
            check($sformatf("slot%0d", k), slot_o[32 * k +: 32],
                  {model_mem[4 * k], model_mem[4 * k + 1], model_mem[4 * k + 2], model_mem[4 * k + 3]});
    endtask

    task automatic set_idle();
        mem_write_i = 1'b0;
        mem_read_i  = 1'b0;
        size_i      = 2'b00;
        unsigned_i  = 1'b0;
        addr_i      = 32'h0;
        wdata_i     = 32'h0;
    endtask

    // One memory operation occupying one clock cycle.
    task automatic access(input bit rd, input bit wr, input logic [1:0] sz, input bit uns,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input bit use_c, input logic [31:0] c);
        bit mis;
        logic [31:0] exp_rd;
        @(negedge clk);
        mem_read_i  = rd;
        mem_write_i = wr;
        size_i      = sz;
        unsigned_i  = uns;
        addr_i      = addr;
        wdata_i     = wd;
        mis    = model_mis(sz, addr);
        exp_rd = (rd && !mis) ? model_load(sz, uns, addr) : 32'h0;
        #1;
        check("rdata", rdata_o, exp_rd);
        if (use_c) check("rdata_const", rdata_o, c);
        @(posedge clk);
        if (wr && !mis) model_store(sz, addr, wd);
        #1;
        check("misalign", {31'h0, misalign_o}, {31'h0, mis && (rd || wr)});
        set_idle();
    endtask

    // Reset pulse then measure the init window; optionally hammer ops during init.
    task automatic reset_seq(input bit poke);
        int cycles;
        @(negedge clk);
        in_i  = in_val;
        rst_i = 1'b1;
        set_idle();
        repeat (2) @(negedge clk);
        rst_i = 1'b0;
        model_reset();
        if (poke) begin
            mem_read_i  = 1'b1;
            mem_write_i = 1'b1;
            size_i      = 2'($urandom_range(0, 3));
            addr_i      = $urandom;
            wdata_i     = $urandom;
        end
        #1;
        check("busy_after_rst", {31'h0, busy_o}, 32'h1);
        check("init_rdata", rdata_o, 32'h0);
        cycles = 0;
        while (cycles < 100) begin
            @(posedge clk);
            #1;
            cycles++;
            check("init_misalign", {31'h0, misalign_o}, 32'h0);
            if (!busy_o) break;
            check("init_rdata", rdata_o, 32'h0);
            if (poke) begin
                size_i  = 2'($urandom_range(0, 3));
                addr_i  = $urandom;
                wdata_i = $urandom;
            end
        end
        set_idle();
        check("init_len", cycles, WORDS);
    endtask

    initial begin
        rst_i  = 1'b1;
        in_val = 32'h8765_4321;
        in_i   = in_val;
        set_idle();

        reset_seq(1'b0);
        check_view();
`ifdef DMEM_PRELOAD_EN
        check("out_preload", out_o, 32'h8765_4321);
        check("slot0_preload", slot_o[31:0], 32'h0000_0008);
        check("slot7_preload", slot_o[255:224], 32'h0000_0001);
`else
        check("out_cleared", out_o, 32'h0);
`endif

        // Big-endian word store and extended sub-word loads.
        access(0, 1, 2'b10, 0, 32'h10, 32'hDEAD_BEEF, 0, 32'h0);
        access(1, 0, 2'b10, 0, 32'h10, 32'h0, 1, 32'hDEAD_BEEF);
        access(1, 0, 2'b00, 0, 32'h10, 32'h0, 1, 32'hFFFF_FFDE);
        access(1, 0, 2'b00, 1, 32'h13, 32'h0, 1, 32'h0000_00EF);
        access(1, 0, 2'b01, 0, 32'h12, 32'h0, 1, 32'hFFFF_BEEF);
        access(1, 0, 2'b01, 1, 32'h10, 32'h0, 1, 32'h0000_DEAD);

        // Half and byte stores into one word.
        access(0, 1, 2'b01, 0, 32'h06, 32'h0000_1234, 0, 32'h0);
        access(1, 0, 2'b10, 0, 32'h04, 32'h0, 1, 32'h0000_1234);
        access(0, 1, 2'b00, 0, 32'h07, 32'h0000_007F, 0, 32'h0);
        access(1, 0, 2'b10, 0, 32'h04, 32'h0, 1, 32'h0000_127F);
        check("slot1_nibble", {28'h0, out_o[27:24]}, 32'hF);

        // Misaligned accesses leave memory untouched.
        access(0, 1, 2'b10, 0, 32'h05, 32'hCAFE_F00D, 0, 32'h0);
        access(1, 0, 2'b01, 0, 32'h03, 32'h0, 1, 32'h0);
        access(1, 0, 2'b00, 0, 32'h03, 32'h0, 0, 32'h0);
        access(1, 0, 2'b11, 0, 32'h06, 32'h0, 1, 32'h0);
        access(1, 0, 2'b10, 0, 32'h04, 32'h0, 1, 32'h0000_127F);

        // Aliasing and same-cycle read/write.
        access(0, 1, 2'b10, 0, 32'h20, 32'h1111_2222, 0, 32'h0);
        access(1, 0, 2'b10, 0, 32'h00, 32'h0, 1, 32'h1111_2222);
        access(1, 1, 2'b10, 0, 32'hFFFF_FF00, 32'h3333_4444, 1, 32'h1111_2222);
        access(1, 0, 2'b10, 0, 32'h40, 32'h0, 1, 32'h3333_4444);
        check_view();

        for (int i = 0; i < 300; i++) begin
            logic [31:0] ra;
            ra = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, DEPTH - 1));
            access(1'($urandom), 1'($urandom), 2'($urandom_range(0, 3)), 1'($urandom),
                   ra, $urandom, 0, 32'h0);
            if (i % 50 == 49) check_view();
        end

        // Reset mid-run with ops hammered during init.
        in_val = $urandom;
        reset_seq(1'b1);
        check_view();
        for (int w = 0; w < WORDS; w++)
            access(1, 0, 2'b10, 0, 32'(4 * w), 32'h0, 0, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed no completion, required finish before 200000");
        $fatal(1, "timeout");
    end

endmodule
